// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Transaction bundle of the serial subtractor: start/operands in, busy/done/result out.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = sub_pkg::DEFAULT_WIDTH
);

  logic             start_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             bo_in;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] diff_out;
  logic             borrow_out;

  modport master (
    output start_in, a_in, b_in, bo_in,
    input  busy_out, done_out, diff_out, borrow_out
  );

  modport slave (
    input  start_in, a_in, b_in, bo_in,
    output busy_out, done_out, diff_out, borrow_out
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor_1.sv
// One-bit full subtractor cell: diff = a ^ b ^ bo, borrow out of a - b - bo.
module full_subtractor_1 (
  input  logic a_in,
  input  logic b_in,
  input  logic bo_in,
  output logic diff_out,
  output logic borrow_out
);

  logic w_axb;

  assign w_axb      = a_in ^ b_in;
  assign diff_out   = w_axb ^ bo_in;
  assign borrow_out = (~a_in & b_in) | (~w_axb & bo_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first: diff = (a - b - bo) mod 2^WIDTH in WIDTH shift cycles.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_d;
  logic             w_bo;

  full_subtractor_1 u_cell (
    .a_in       (r_a[0]),
    .b_in       (r_b[0]),
    .bo_in      (r_br),
    .diff_out   (w_d),
    .borrow_out (w_bo)
  );

  // FSM, datapath shift registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_br     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start_in) begin
            r_a     <= bus.a_in;
            r_b     <= bus.b_in;
            r_br    <= bus.bo_in;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_bo;
          r_res <= {w_d, r_res[WIDTH-1:1]};
          if (r_cnt == CW'(WIDTH - 1)) begin
            // last bit: publish the completed word together with the final borrow
            r_diff   <= {w_d, r_res[WIDTH-1:1]};
            r_borrow <= w_bo;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy_out   = r_busy;
  assign bus.done_out   = r_done;
  assign bus.diff_out   = r_diff;
  assign bus.borrow_out = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and table-driven bench for serial_subtractor at WIDTH=4 and WIDTH=8.
module tb_serial_subtractor;

  logic clk;
  logic rst_n;

  serial_subtractor_if #(.WIDTH(4)) if4 ();
  serial_subtractor_if #(.WIDTH(8)) if8 ();

  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bo;
    logic [3:0] diff;
    logic       borrow;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input bit w8, input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic bo);
    if (w8) begin
      if8.start_in = s; if8.a_in = a; if8.b_in = b; if8.bo_in = bo;
    end else begin
      if4.start_in = s; if4.a_in = a[3:0]; if4.b_in = b[3:0]; if4.bo_in = bo;
    end
  endtask

  function automatic logic get_busy(input bit w8);
    return w8 ? if8.busy_out : if4.busy_out;
  endfunction

  function automatic logic get_done(input bit w8);
    return w8 ? if8.done_out : if4.done_out;
  endfunction

  function automatic logic [7:0] get_diff(input bit w8);
    return w8 ? if8.diff_out : {4'h0, if4.diff_out};
  endfunction

  function automatic logic get_br(input bit w8);
    return w8 ? if8.borrow_out : if4.borrow_out;
  endfunction

  // Start one op at the next edge, optionally pulse start with junk operands at edge poke_k,
  // and return result, done latency (edges after accept) and number of busy cycles.
  task automatic run_op(input bit w8, input logic [7:0] a, input logic [7:0] b, input logic bo,
                        input int poke_k, output logic [7:0] d, output logic br,
                        output int lat, output int nbusy);
    set_in(w8, 1'b1, a, b, bo);
    @(posedge clk); #1;
    set_in(w8, 1'b0, ~a, ~b, ~bo);
    nbusy = get_busy(w8) ? 1 : 0;
    lat   = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (get_done(w8)) begin
        lat = k;
        break;
      end
      if (get_busy(w8)) nbusy++;
      if (k == poke_k)          set_in(w8, 1'b1, 8'h01, 8'h02, 1'b1);
      else if (k == poke_k + 1) set_in(w8, 1'b0, 8'h00, 8'h00, 1'b0);
    end
    d  = get_diff(w8);
    br = get_br(w8);
  endtask

  task automatic check_op(input string nm, input bit w8, input logic [7:0] a, input logic [7:0] b,
                          input logic bo, input logic [7:0] ed, input logic eb, input int poke_k);
    logic [7:0] d;
    logic       br;
    int         lat;
    int         nbusy;
    int         w;
    w = w8 ? 8 : 4;
    run_op(w8, a, b, bo, poke_k, d, br, lat, nbusy);
    chk({nm, " diff"}, 32'(d), 32'(ed));
    chk({nm, " borrow"}, 32'(br), 32'(eb));
    chk({nm, " latency"}, 32'(lat), 32'(w));
    chk({nm, " busy_cycles"}, 32'(nbusy), 32'(w));
    @(posedge clk); #1;
    chk({nm, " done_low_after"}, 32'(get_done(w8)), 32'd0);
    chk({nm, " diff_held"}, 32'(get_diff(w8)), 32'(ed));
  endtask

  vec_t vecs[$];

  initial begin
    logic [7:0] ra, rb;
    logic       rbo;
    logic [8:0] full;
    int         dones[$];

    set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    set_in(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b0;

    vecs.push_back('{4'd9,  4'd3,  1'b0, 4'h6, 1'b0});
    vecs.push_back('{4'd3,  4'd9,  1'b0, 4'hA, 1'b1});
    vecs.push_back('{4'd0,  4'd0,  1'b1, 4'hF, 1'b1});
    vecs.push_back('{4'd7,  4'd7,  1'b0, 4'h0, 1'b0});
    vecs.push_back('{4'd15, 4'd0,  1'b1, 4'hE, 1'b0});
    vecs.push_back('{4'd8,  4'd8,  1'b1, 4'hF, 1'b1});
    vecs.push_back('{4'd0,  4'd15, 1'b0, 4'h1, 1'b1});
    vecs.push_back('{4'd12, 4'd5,  1'b1, 4'h6, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy4", 32'(if4.busy_out), 32'd0);
    chk("reset done4", 32'(if4.done_out), 32'd0);
    chk("reset diff4", 32'(if4.diff_out), 32'd0);
    chk("reset borrow4", 32'(if4.borrow_out), 32'd0);
    chk("reset diff8", 32'(if8.diff_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      check_op($sformatf("vec%0d", i), 1'b0, {4'h0, vecs[i].a}, {4'h0, vecs[i].b}, vecs[i].bo,
               {4'h0, vecs[i].diff}, vecs[i].borrow, 0);

    // start re-pulsed mid-SHIFT with other operands must be ignored
    check_op("ignore_start", 1'b0, 8'd9, 8'd3, 1'b0, 8'd6, 1'b0, 2);
    repeat (3) @(posedge clk);
    #1;
    chk("ignore_start no_new_op", 32'(if4.busy_out), 32'd0);

    // reset asserted two cycles into SHIFT aborts the op
    set_in(1'b0, 1'b1, 8'd9, 8'd3, 1'b0);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort busy_before", 32'(if4.busy_out), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(if4.busy_out), 32'd0);
    chk("abort diff", 32'(if4.diff_out), 32'd0);
    chk("abort borrow", 32'(if4.borrow_out), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k == 1) rst_n = 1'b1;
      chk("abort no_done", 32'(if4.done_out), 32'd0);
    end
    check_op("after_abort", 1'b0, 8'd7, 8'd7, 1'b0, 8'd0, 1'b0, 0);

    // start held high: back-to-back ops, 5-2 then 2-5
    set_in(1'b0, 1'b1, 8'd5, 8'd2, 1'b0);
    @(posedge clk); #1;
    set_in(1'b0, 1'b1, 8'd2, 8'd5, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (if4.done_out) begin
        dones.push_back(k);
        if (dones.size() == 1) begin
          chk("held op1 diff", 32'(if4.diff_out), 32'h3);
          chk("held op1 borrow", 32'(if4.borrow_out), 32'd0);
        end else begin
          chk("held op2 diff", 32'(if4.diff_out), 32'hD);
          chk("held op2 borrow", 32'(if4.borrow_out), 32'd1);
          break;
        end
      end
    end
    set_in(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    chk("held done_count", 32'(dones.size()), 32'd2);
    if (dones.size() == 2) begin
      chk("held first_latency", 32'(dones[0]), 32'd4);
      chk("held done_spacing", 32'(dones[1] - dones[0]), 32'd6);
    end
    repeat (8) @(posedge clk);
    #1;

    // WIDTH=8 instance
    check_op("w8 200-55", 1'b1, 8'd200, 8'd55, 1'b0, 8'd145, 1'b0, 0);
    check_op("w8 0-0-1", 1'b1, 8'd0, 8'd0, 1'b1, 8'hFF, 1'b1, 0);
    for (int i = 0; i < 12; i++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      rbo  = 1'($urandom_range(0, 1));
      full = {1'b0, ra} - {1'b0, rb} - 9'(rbo);
      check_op($sformatf("w8 rand%0d", i), 1'b1, ra, rb, rbo, full[7:0], full[8], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
